// File: rtl/ahb3lite_interconnect_master_port.sv
// Master-side switch port: decodes the address, broadcasts address/data to the slave ports, and returns the selected response.
// Zero latency when granted; holds the transfer and stalls the master until the slave port grants it; unmapped addresses get a 2-cycle ERROR.
module ahb3lite_interconnect_master_port #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int SLAVES     = 8
) (
  input  logic                                   HCLK,
  input  logic                                   HRESET,

  input  logic [SLAVES-1:0][HADDR_SIZE-1:0]      slvHADDRbase,
  input  logic [SLAVES-1:0][HADDR_SIZE-1:0]      slvHADDRmask,

  input  logic                                   mstHSEL,
  input  logic [HADDR_SIZE-1:0]                  mstHADDR,
  input  logic [HDATA_SIZE-1:0]                  mstHWDATA,
  input  logic                                   mstHWRITE,
  input  logic [2:0]                             mstHSIZE,
  input  logic [2:0]                             mstHBURST,
  input  logic [3:0]                             mstHPROT,
  input  logic [1:0]                             mstHTRANS,
  input  logic                                   mstHMASTLOCK,
  input  logic                                   mstHREADY,
  output logic [HDATA_SIZE-1:0]                  mstHRDATA,
  output logic                                   mstHREADYOUT,
  output logic                                   mstHRESP,

  output logic [SLAVES-1:0]                      slvHSEL,
  output logic [HADDR_SIZE-1:0]                  slvHADDR,
  output logic [HDATA_SIZE-1:0]                  slvHWDATA,
  output logic                                   slvHWRITE,
  output logic [2:0]                             slvHSIZE,
  output logic [2:0]                             slvHBURST,
  output logic [3:0]                             slvHPROT,
  output logic [1:0]                             slvHTRANS,
  output logic                                   slvHMASTLOCK,
  output logic                                   slvHREADYOUT,
  input  logic [SLAVES-1:0]                      slvHREADY,
  input  logic [SLAVES-1:0]                      slvHRESP,
  input  logic [SLAVES-1:0][HDATA_SIZE-1:0]      slvHRDATA,

  input  logic [SLAVES-1:0]                      granted,
  output logic [SLAVES-1:0]                      can_switch
);

  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GRANT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [HADDR_SIZE-1:0] r_haddr;
  logic                  r_hwrite;
  logic [2:0]            r_hsize;
  logic [2:0]            r_hburst;
  logic [3:0]            r_hprot;
  logic [1:0]            r_htrans;
  logic                  r_hmastlock;
  logic [SLAVES-1:0]     r_htgt;
  logic [SLAVES-1:0]     r_dtgt;

  logic [SLAVES-1:0]     w_match;
  logic [SLAVES-1:0]     w_tgt;
  logic                  w_mapped;
  logic                  w_accept;
  logic                  w_tgrant;
  logic                  w_hgrant;
  logic                  w_hready;
  logic                  w_hgo;
  logic                  w_dready;
  logic                  w_dresp;
  logic [HDATA_SIZE-1:0] w_drdata;
  logic                  w_hreadyout;
  logic                  w_hresp;
  logic                  w_nolose;

  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      w_match[s] = ((mstHADDR ^ slvHADDRbase[s]) & slvHADDRmask[s]) == '0;
    end
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    w_tgt = '0;
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if (w_match[s]) begin
        w_tgt    = '0;
        w_tgt[s] = 1'b1;
      end
    end
  end

  assign w_mapped = |w_match;
  assign w_accept = mstHSEL & mstHREADY & mstHTRANS[1];
  assign w_tgrant = |(granted & w_tgt);
  assign w_hgrant = |(granted & r_htgt);
  assign w_hready = |(slvHREADY & r_htgt);
  assign w_hgo    = (r_state == ST_WAIT_GRANT) & w_hgrant & w_hready;

  always_comb begin
    w_dready = 1'b0;
    w_dresp  = 1'b0;
    w_drdata = '0;
    for (int s = 0; s < SLAVES; s++) begin
      if (r_dtgt[s]) begin
        w_dready = w_dready | slvHREADY[s];
        w_dresp  = w_dresp  | slvHRESP[s];
        w_drdata = w_drdata | slvHRDATA[s];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_hburst    <= '0;
      r_hprot     <= '0;
      r_htrans    <= '0;
      r_hmastlock <= 1'b0;
      r_htgt      <= '0;
      r_dtgt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_haddr     <= mstHADDR;
        r_hwrite    <= mstHWRITE;
        r_hsize     <= mstHSIZE;
        r_hburst    <= mstHBURST;
        r_hprot     <= mstHPROT;
        r_htrans    <= mstHTRANS;
        r_hmastlock <= mstHMASTLOCK;
        r_htgt      <= w_tgt;
      end
      if (w_hreadyout && w_accept) begin
        r_dtgt <= w_tgt;
      end else if (w_hgo) begin
        r_dtgt <= r_htgt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    case (r_state)
      ST_WAIT_GRANT: w_hreadyout = 1'b0;
      ST_DATA: begin
        w_hreadyout = w_dready;
        w_hresp     = w_dresp;
      end
      ST_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
      end
      ST_ERR2: w_hresp = 1'b1;
      default: ;
    endcase

    if (w_hreadyout) begin
      if (!w_accept)      w_state_nxt = ST_IDLE;
      else if (!w_mapped) w_state_nxt = ST_ERR1;
      else if (w_tgrant)  w_state_nxt = ST_DATA;
      else                w_state_nxt = ST_WAIT_GRANT;
    end else if (w_hgo) begin
      w_state_nxt = ST_DATA;
    end else if (r_state == ST_ERR1) begin
      w_state_nxt = ST_ERR2;
    end
  end

  assign mstHREADYOUT = w_hreadyout;
  assign mstHRESP     = w_hresp;
  assign mstHRDATA    = (r_state == ST_DATA) ? w_drdata : '0;
  assign slvHWDATA    = mstHWDATA;

  // A held SEQ restarts the burst at the new slave port, so it goes out as NONSEQ.
  always_comb begin
    if (r_state == ST_WAIT_GRANT) begin
      slvHSEL      = r_htgt;
      slvHADDR     = r_haddr;
      slvHWRITE    = r_hwrite;
      slvHSIZE     = r_hsize;
      slvHBURST    = r_hburst;
      slvHPROT     = r_hprot;
      slvHTRANS    = (r_htrans == HTRANS_SEQ) ? HTRANS_NONSEQ : r_htrans;
      slvHMASTLOCK = r_hmastlock;
      slvHREADYOUT = w_hready;
    end else begin
      slvHSEL      = w_tgt & {SLAVES{mstHSEL}};
      slvHADDR     = mstHADDR;
      slvHWRITE    = mstHWRITE;
      slvHSIZE     = mstHSIZE;
      slvHBURST    = mstHBURST;
      slvHPROT     = mstHPROT;
      slvHTRANS    = mstHTRANS;
      slvHMASTLOCK = mstHMASTLOCK;
      slvHREADYOUT = w_hreadyout;
    end
  end

  assign w_nolose = slvHMASTLOCK | (slvHTRANS == HTRANS_SEQ) | (slvHTRANS == HTRANS_BUSY);

  always_comb begin
    for (int s = 0; s < SLAVES; s++) begin
      can_switch[s] = ~(slvHSEL[s] & (w_nolose | ((r_state == ST_WAIT_GRANT) & r_htgt[s])));
    end
  end

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Directed bench for the master-side switch port: decode, grant stall, error response, lock and reset.
module tb_ahb3lite_interconnect_master_port;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 8;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic                    HCLK = 1'b0;
  logic                    HRESET;
  logic [NS-1:0][AW-1:0]   slvHADDRbase;
  logic [NS-1:0][AW-1:0]   slvHADDRmask;
  logic                    mstHSEL;
  logic [AW-1:0]           mstHADDR;
  logic [DW-1:0]           mstHWDATA;
  logic                    mstHWRITE;
  logic [2:0]              mstHSIZE;
  logic [2:0]              mstHBURST;
  logic [3:0]              mstHPROT;
  logic [1:0]              mstHTRANS;
  logic                    mstHMASTLOCK;
  logic                    mstHREADY;
  logic [DW-1:0]           mstHRDATA;
  logic                    mstHREADYOUT;
  logic                    mstHRESP;
  logic [NS-1:0]           slvHSEL;
  logic [AW-1:0]           slvHADDR;
  logic [DW-1:0]           slvHWDATA;
  logic                    slvHWRITE;
  logic [2:0]              slvHSIZE;
  logic [2:0]              slvHBURST;
  logic [3:0]              slvHPROT;
  logic [1:0]              slvHTRANS;
  logic                    slvHMASTLOCK;
  logic                    slvHREADYOUT;
  logic [NS-1:0]           slvHREADY;
  logic [NS-1:0]           slvHRESP;
  logic [NS-1:0][DW-1:0]   slvHRDATA;
  logic [NS-1:0]           granted;
  logic [NS-1:0]           can_switch;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  // Single-master layer: the bus HREADY is this port's own HREADYOUT.
  assign mstHREADY = mstHREADYOUT;

  ahb3lite_interconnect_master_port #(
    .HADDR_SIZE(AW),
    .HDATA_SIZE(DW),
    .SLAVES(NS)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .slvHADDRbase(slvHADDRbase),
    .slvHADDRmask(slvHADDRmask),
    .mstHSEL(mstHSEL),
    .mstHADDR(mstHADDR),
    .mstHWDATA(mstHWDATA),
    .mstHWRITE(mstHWRITE),
    .mstHSIZE(mstHSIZE),
    .mstHBURST(mstHBURST),
    .mstHPROT(mstHPROT),
    .mstHTRANS(mstHTRANS),
    .mstHMASTLOCK(mstHMASTLOCK),
    .mstHREADY(mstHREADY),
    .mstHRDATA(mstHRDATA),
    .mstHREADYOUT(mstHREADYOUT),
    .mstHRESP(mstHRESP),
    .slvHSEL(slvHSEL),
    .slvHADDR(slvHADDR),
    .slvHWDATA(slvHWDATA),
    .slvHWRITE(slvHWRITE),
    .slvHSIZE(slvHSIZE),
    .slvHBURST(slvHBURST),
    .slvHPROT(slvHPROT),
    .slvHTRANS(slvHTRANS),
    .slvHMASTLOCK(slvHMASTLOCK),
    .slvHREADYOUT(slvHREADYOUT),
    .slvHREADY(slvHREADY),
    .slvHRESP(slvHRESP),
    .slvHRDATA(slvHRDATA),
    .granted(granted),
    .can_switch(can_switch)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic mst(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                     input logic wr, input logic [2:0] burst, input logic lock);
    mstHSEL      = sel;
    mstHTRANS    = trans;
    mstHADDR     = addr;
    mstHWRITE    = wr;
    mstHBURST    = burst;
    mstHMASTLOCK = lock;
  endtask

  initial begin
    for (int s = 0; s < NS; s++) begin
      slvHADDRbase[s] = 32'(s) << 28;
      slvHADDRmask[s] = 32'hF000_0000;
      slvHRDATA[s]    = 32'hA000_0000 + 32'(s);
    end
    HRESET    = 1'b1;
    mst(1'b0, T_IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
    mstHWDATA = '0;
    mstHSIZE  = 3'b010;
    mstHPROT  = 4'b0011;
    granted   = 8'h03;
    slvHREADY = 8'hFF;
    slvHRESP  = 8'h00;
    tick();
    tick();
    chk("rst_rdy",   64'(mstHREADYOUT), 64'h1);
    chk("rst_resp",  64'(mstHRESP),     64'h0);
    chk("rst_rdata", 64'(mstHRDATA),    64'h0);
    chk("rst_hsel",  64'(slvHSEL),      64'h0);
    chk("rst_cs",    64'(can_switch),   64'hFF);
    HRESET = 1'b0;

    // granted read to slave 1
    mst(1'b1, T_NONSEQ, 32'h1000_0004, 1'b0, 3'b000, 1'b0);
    #1;
    chk("t1_hsel",  64'(slvHSEL),  64'h02);
    chk("t1_haddr", 64'(slvHADDR), 64'h1000_0004);
    chk("t1_cs",    64'(can_switch), 64'hFF);
    tick();
    mst(1'b0, T_IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
    #1;
    chk("t1_rdata", 64'(mstHRDATA),    64'hA000_0001);
    chk("t1_drdy",  64'(mstHREADYOUT), 64'h1);
    slvHREADY[1] = 1'b0;
    #1;
    chk("t1_dwait",  64'(mstHREADYOUT), 64'h0);
    chk("t1_sready", 64'(slvHREADYOUT), 64'h0);
    slvHREADY[1] = 1'b1;
    tick();
    chk("t1_idle_rdata", 64'(mstHRDATA), 64'h0);

    // unmapped address
    mst(1'b1, T_NONSEQ, 32'h8000_0000, 1'b0, 3'b000, 1'b0);
    #1;
    chk("t2_hsel", 64'(slvHSEL), 64'h0);
    tick();
    mst(1'b0, T_IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
    #1;
    chk("t2_e1_rdy",  64'(mstHREADYOUT), 64'h0);
    chk("t2_e1_resp", 64'(mstHRESP),     64'h1);
    tick();
    chk("t2_e2_rdy",  64'(mstHREADYOUT), 64'h1);
    chk("t2_e2_resp", 64'(mstHRESP),     64'h1);
    tick();
    chk("t2_idle_rdy",  64'(mstHREADYOUT), 64'h1);
    chk("t2_idle_resp", 64'(mstHRESP),     64'h0);

    // IDLE htrans with HSEL is not forwarded as a transfer
    mst(1'b1, T_IDLE, 32'h1000_0000, 1'b0, 3'b000, 1'b0);
    tick();
    mst(1'b0, T_IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
    #1;
    chk("t2b_rdata", 64'(mstHRDATA),    64'h0);
    chk("t2b_rdy",   64'(mstHREADYOUT), 64'h1);

    // ungranted write to slave 1, held for 3 cycles
    granted = 8'h01;
    mst(1'b1, T_NONSEQ, 32'h1000_0010, 1'b1, 3'b000, 1'b0);
    #1;
    chk("t3_live_hsel", 64'(slvHSEL), 64'h02);
    tick();
    mst(1'b1, T_NONSEQ, 32'h0000_0020, 1'b0, 3'b000, 1'b0);
    mstHWDATA = 32'hDEAD_BEEF;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_w_rdy",   64'(mstHREADYOUT), 64'h0);
      chk("t3_w_hsel",  64'(slvHSEL),      64'h02);
      chk("t3_w_haddr", 64'(slvHADDR),     64'h1000_0010);
      chk("t3_w_trans", 64'(slvHTRANS),    64'h2);
      chk("t3_w_write", 64'(slvHWRITE),    64'h1);
      chk("t3_w_cs",    64'(can_switch),   64'hFD);
      if (i == 1) begin
        slvHREADY[1] = 1'b0;
        #1;
        chk("t3_w_sready0", 64'(slvHREADYOUT), 64'h0);
        slvHREADY[1] = 1'b1;
        #1;
        chk("t3_w_sready1", 64'(slvHREADYOUT), 64'h1);
      end
      tick();
    end
    granted = 8'h03;
    #1;
    chk("t3_g_rdy", 64'(mstHREADYOUT), 64'h0);
    tick();
    chk("t3_wdata",   64'(slvHWDATA),    64'hDEAD_BEEF);
    chk("t3_d_rdy",   64'(mstHREADYOUT), 64'h1);
    chk("t3_d_rdata", 64'(mstHRDATA),    64'hA000_0001);
    chk("t3_d_hsel",  64'(slvHSEL),      64'h01);
    tick();
    mst(1'b0, T_IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
    #1;
    chk("t3_b2b_rdata", 64'(mstHRDATA), 64'hA000_0000);
    tick();

    // INCR4 burst crossing from slave 0 to ungranted slave 1
    granted = 8'h01;
    mst(1'b1, T_NONSEQ, 32'h0FFF_FFF8, 1'b0, 3'b011, 1'b0);
    #1;
    chk("t4_b0_hsel", 64'(slvHSEL), 64'h01);
    tick();
    mst(1'b1, T_SEQ, 32'h0FFF_FFFC, 1'b0, 3'b011, 1'b0);
    #1;
    chk("t4_b1_cs", 64'(can_switch), 64'hFE);
    tick();
    mst(1'b1, T_SEQ, 32'h1000_0000, 1'b0, 3'b011, 1'b0);
    #1;
    chk("t4_b2_hsel", 64'(slvHSEL),    64'h02);
    chk("t4_b2_cs",   64'(can_switch), 64'hFD);
    tick();
    mst(1'b1, T_SEQ, 32'h1000_0004, 1'b0, 3'b011, 1'b0);
    #1;
    chk("t4_w_trans", 64'(slvHTRANS),    64'h2);
    chk("t4_w_addr",  64'(slvHADDR),     64'h1000_0000);
    chk("t4_w_burst", 64'(slvHBURST),    64'h3);
    chk("t4_w_cs",    64'(can_switch),   64'hFD);
    chk("t4_w_rdy",   64'(mstHREADYOUT), 64'h0);
    granted = 8'h03;
    tick();
    chk("t4_b3_trans", 64'(slvHTRANS),    64'h3);
    chk("t4_b3_rdy",   64'(mstHREADYOUT), 64'h1);
    tick();
    mst(1'b0, T_IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
    tick();

    // locked transfer to slave 0
    mst(1'b1, T_NONSEQ, 32'h0000_0040, 1'b0, 3'b000, 1'b1);
    #1;
    chk("t5_cs",   64'(can_switch),   64'hFE);
    chk("t5_lock", 64'(slvHMASTLOCK), 64'h1);
    tick();
    mst(1'b0, T_IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
    tick();

    // reset while waiting for a grant
    granted = 8'h01;
    mst(1'b1, T_NONSEQ, 32'h1000_0080, 1'b1, 3'b000, 1'b0);
    tick();
    mst(1'b0, T_IDLE, 32'h0, 1'b0, 3'b000, 1'b0);
    #1;
    chk("t6_wait_rdy", 64'(mstHREADYOUT), 64'h0);
    HRESET = 1'b1;
    tick();
    chk("t6_rst_rdy",  64'(mstHREADYOUT), 64'h1);
    chk("t6_rst_resp", 64'(mstHRESP),     64'h0);
    chk("t6_rst_cs",   64'(can_switch),   64'hFF);
    chk("t6_rst_hsel", 64'(slvHSEL),      64'h0);
    HRESET  = 1'b0;
    granted = 8'h03;
    tick();
    chk("t6_post_hsel",  64'(slvHSEL),      64'h0);
    chk("t6_post_rdata", 64'(mstHRDATA),    64'h0);
    chk("t6_post_rdy",   64'(mstHREADYOUT), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
